// File: rtl/ecc_bist_seq.sv
// ECC built-in self-test sequencer: drives the test-module self-test strobe,
// samples its result word once per iteration and reports a run verdict.
module ecc_bist_seq #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned REPEAT_NUM = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bist_start,
  input  logic        bist_abort,
  input  logic        ecc_enable,
  input  logic [37:0] if_data_in,
  output logic        ecc_bist3,
  output logic        bist_busy,
  output logic        bist_done,
  output logic        bist_pass,
  output logic [3:0]  bist_err_cnt,
  output logic [1:0]  bist_status
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] ERR_MAX = '1;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_PASS = 2'b10;
  localparam logic [1:0] ST_FAIL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_SAMPLE = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   settle_cnt, settle_nxt;
  logic [CW-1:0]   iter_cnt, iter_nxt;
  logic [CW-1:0]   err_nxt;
  logic            pass_nxt;
  logic [1:0]      status_nxt;
  logic            run_active;

  // Next-state and next-output decode; abort handling overrides the per-state result.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    iter_nxt   = iter_cnt;
    err_nxt    = bist_err_cnt;
    pass_nxt   = bist_pass;
    status_nxt = bist_status;
    run_active = (state == S_SETUP) || (state == S_SAMPLE) || (state == S_GAP);

    case (state)
      S_IDLE: begin
        if (bist_start && !bist_abort) begin
          pass_nxt = 1'b0;
          if (ecc_enable) begin
            state_nxt  = S_SETUP;
            settle_nxt = '0;
            iter_nxt   = '0;
            err_nxt    = '0;
            status_nxt = ST_RUN;
          end else begin
            state_nxt  = S_DONE;
            err_nxt    = ERR_MAX;
            status_nxt = ST_FAIL;
          end
        end
      end
      S_SETUP: begin
        if (settle_cnt == CW'(SETTLE_CYC - 1)) begin
          state_nxt  = S_SAMPLE;
          settle_nxt = '0;
        end else begin
          settle_nxt = settle_cnt + CW'(1);
        end
      end
      S_SAMPLE: begin
        if ((if_data_in != '0) && (bist_err_cnt != ERR_MAX)) begin
          err_nxt = bist_err_cnt + CW'(1);
        end
        state_nxt = S_GAP;
      end
      S_GAP: begin
        iter_nxt = iter_cnt + CW'(1);
        if (iter_nxt == CW'(REPEAT_NUM)) begin
          state_nxt  = S_DONE;
          pass_nxt   = (bist_err_cnt == '0);
          status_nxt = (bist_err_cnt == '0) ? ST_PASS : ST_FAIL;
        end else begin
          state_nxt = S_SETUP;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Losing the ECC path mid-run is handled like an explicit abort.
    if (((state != S_IDLE) && bist_abort) || (run_active && !ecc_enable)) begin
      state_nxt  = S_IDLE;
      settle_nxt = '0;
      iter_nxt   = '0;
      err_nxt    = bist_err_cnt;
      pass_nxt   = 1'b0;
      status_nxt = ST_IDLE;
    end
  end

  // State, counters and all outputs are flops loaded from the decoded next values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      settle_cnt   <= '0;
      iter_cnt     <= '0;
      ecc_bist3    <= 1'b0;
      bist_busy    <= 1'b0;
      bist_done    <= 1'b0;
      bist_pass    <= 1'b0;
      bist_err_cnt <= '0;
      bist_status  <= ST_IDLE;
    end else begin
      state        <= state_nxt;
      settle_cnt   <= settle_nxt;
      iter_cnt     <= iter_nxt;
      ecc_bist3    <= (state_nxt == S_SETUP) || (state_nxt == S_SAMPLE);
      bist_busy    <= (state_nxt != S_IDLE);
      bist_done    <= (state_nxt == S_DONE);
      bist_pass    <= pass_nxt;
      bist_err_cnt <= err_nxt;
      bist_status  <= status_nxt;
    end
  end

endmodule

// File: tb/tb_ecc_bist_seq.sv
// Bench for ecc_bist_seq: vector table, randomized runs against a per-iteration
// reference model, and hand-written abort/enable/reset sequences.
module tb_ecc_bist_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        enable;
  logic [37:0] data;
  logic        b3, busy, done, pass;
  logic [3:0]  err;
  logic [1:0]  status;

  logic        s15_start;
  logic        s15_b3, s15_busy, s15_done, s15_pass;
  logic [3:0]  s15_err;
  logic [1:0]  s15_status;

  int total = 0;
  int bad   = 0;

  ecc_bist_seq u_dut (
    .clk(clk), .rst_n(rst_n), .bist_start(start), .bist_abort(abort),
    .ecc_enable(enable), .if_data_in(data), .ecc_bist3(b3), .bist_busy(busy),
    .bist_done(done), .bist_pass(pass), .bist_err_cnt(err), .bist_status(status)
  );

  ecc_bist_seq #(.SETTLE_CYC(4), .REPEAT_NUM(15)) u_dut15 (
    .clk(clk), .rst_n(rst_n), .bist_start(s15_start), .bist_abort(1'b0),
    .ecc_enable(1'b1), .if_data_in(38'h0F), .ecc_bist3(s15_b3), .bist_busy(s15_busy),
    .bist_done(s15_done), .bist_pass(s15_pass), .bist_err_cnt(s15_err), .bist_status(s15_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] mask;
    logic [3:0] err;
    logic       pass;
    logic [1:0] status;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat15(input int n);
    return (n > 15) ? 15 : n;
  endfunction

  // Failing iterations whose result has already been folded into the count at cycle c.
  function automatic int fails_before(input logic [7:0] mask, input int c);
    int n = 0;
    for (int i = 0; i < 8; i++) if (mask[i] && (6 * i + 5 <= c)) n++;
    return n;
  endfunction

  function automatic logic [37:0] fail_word();
    if ($urandom_range(0, 1) == 0) return 38'h0F;
    return 38'({$urandom, $urandom}) | 38'h1;
  endfunction

  // One complete default run; iteration i fails when mask[i] is set.
  task automatic run_full(input logic [7:0] mask, input bit noise, input bit spam,
                          output logic [3:0] f_err, output logic f_pass, output logic [1:0] f_status);
    int tot;
    tot = fails_before(mask, 48);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      chk($sformatf("run c=%0d ecc_bist3", c), 8'(b3), 8'((c < 48) && ((c % 6) < 5)));
      chk($sformatf("run c=%0d busy", c), 8'(busy), 8'(c <= 48));
      chk($sformatf("run c=%0d done", c), 8'(done), 8'(c == 48));
      chk($sformatf("run c=%0d err_cnt", c), 8'(err), 8'(sat15(fails_before(mask, c))));
      chk($sformatf("run c=%0d status", c), 8'(status),
          8'((c < 48) ? 1 : ((tot == 0) ? 2 : 3)));
      chk($sformatf("run c=%0d pass", c), 8'(pass), 8'((c >= 48) && (tot == 0)));
      if ((c < 48) && ((c % 6) == 4)) data = mask[c / 6] ? fail_word() : '0;
      else data = noise ? 38'({$urandom, $urandom}) : '0;
      start = spam && (c < 47) && ($urandom_range(0, 7) == 0);
      tick();
    end
    start  = 1'b0;
    data   = '0;
    f_err  = err;
    f_pass = pass;
    f_status = status;
  endtask

  logic [3:0] r_err;
  logic       r_pass;
  logic [1:0] r_status;
  logic [7:0] rmask;
  int         done_cyc, done_num;

  initial begin
    tbl[0] = '{8'h00, 4'd0, 1'b1, 2'b10};
    tbl[1] = '{8'h44, 4'd2, 1'b0, 2'b11};
    tbl[2] = '{8'hFF, 4'd8, 1'b0, 2'b11};
    tbl[3] = '{8'h01, 4'd1, 1'b0, 2'b11};
    tbl[4] = '{8'h80, 4'd1, 1'b0, 2'b11};
    tbl[5] = '{8'h55, 4'd4, 1'b0, 2'b11};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; enable = 1'b1; data = '0; s15_start = 1'b0;
    #3;
    chk("reset ecc_bist3", 8'(b3), 8'd0);
    chk("reset busy", 8'(busy), 8'd0);
    chk("reset done", 8'(done), 8'd0);
    chk("reset pass", 8'(pass), 8'd0);
    chk("reset err_cnt", 8'(err), 8'd0);
    chk("reset status", 8'(status), 8'd0);
    #10 rst_n = 1'b1;
    tick();
    tick();
    chk("idle busy", 8'(busy), 8'd0);

    for (int k = 0; k < 6; k++) begin
      run_full(tbl[k].mask, 1'b0, 1'b0, r_err, r_pass, r_status);
      chk($sformatf("table %0d err_cnt", k), 8'(r_err), 8'(tbl[k].err));
      chk($sformatf("table %0d pass", k), 8'(r_pass), 8'(tbl[k].pass));
      chk($sformatf("table %0d status", k), 8'(r_status), 8'(tbl[k].status));
    end

    for (int k = 0; k < 24; k++) begin
      rmask = 8'($urandom);
      run_full(rmask, 1'b1, 1'b1, r_err, r_pass, r_status);
    end

    // Abort during the third iteration's settle phase; iteration 0 failed first.
    start = 1'b1; tick(); start = 1'b0;
    data = 38'h0F;
    repeat (6) tick();
    data = '0;
    repeat (7) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort ecc_bist3", 8'(b3), 8'd0);
    chk("abort busy", 8'(busy), 8'd0);
    chk("abort status", 8'(status), 8'd0);
    chk("abort done", 8'(done), 8'd0);
    chk("abort pass", 8'(pass), 8'd0);
    chk("abort err_cnt holds", 8'(err), 8'd1);
    tick();
    chk("abort no late done", 8'(done), 8'd0);
    run_full(8'h00, 1'b0, 1'b0, r_err, r_pass, r_status);
    chk("rerun after abort status", 8'(r_status), 8'd2);

    // Start and abort together in idle: nothing starts.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start+abort busy", 8'(busy), 8'd0);
    chk("start+abort ecc_bist3", 8'(b3), 8'd0);
    tick();
    chk("start+abort busy later", 8'(busy), 8'd0);

    // Start with the ECC path disabled: immediate failing verdict.
    enable = 1'b0; start = 1'b1;
    tick();
    chk("disabled done", 8'(done), 8'd1);
    chk("disabled busy", 8'(busy), 8'd1);
    chk("disabled ecc_bist3", 8'(b3), 8'd0);
    chk("disabled err_cnt", 8'(err), 8'hF);
    chk("disabled status", 8'(status), 8'd3);
    chk("disabled pass", 8'(pass), 8'd0);
    start = 1'b0;
    tick();
    chk("disabled done drop", 8'(done), 8'd0);
    chk("disabled idle busy", 8'(busy), 8'd0);
    chk("disabled idle ecc_bist3", 8'(b3), 8'd0);
    chk("disabled hold status", 8'(status), 8'd3);
    enable = 1'b1;

    // ECC path dropped mid-run behaves as an abort.
    start = 1'b1; tick(); start = 1'b0;
    data = 38'h0F;
    repeat (6) tick();
    data = '0;
    repeat (14) tick();
    enable = 1'b0;
    tick();
    chk("enable drop busy", 8'(busy), 8'd0);
    chk("enable drop ecc_bist3", 8'(b3), 8'd0);
    chk("enable drop status", 8'(status), 8'd0);
    chk("enable drop done", 8'(done), 8'd0);
    chk("enable drop err_cnt", 8'(err), 8'd1);
    enable = 1'b1;
    tick();

    // Asynchronous reset at cycle 20 of a failing run.
    start = 1'b1; tick(); start = 1'b0;
    data = 38'h0F;
    repeat (20) tick();
    chk("pre-reset err_cnt", 8'(err), 8'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-run reset ecc_bist3", 8'(b3), 8'd0);
    chk("mid-run reset busy", 8'(busy), 8'd0);
    chk("mid-run reset done", 8'(done), 8'd0);
    chk("mid-run reset pass", 8'(pass), 8'd0);
    chk("mid-run reset err_cnt", 8'(err), 8'd0);
    chk("mid-run reset status", 8'(status), 8'd0);
    #1 rst_n = 1'b1;
    data = '0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("post-reset c=%0d busy", c), 8'(busy), 8'd0);
      chk($sformatf("post-reset c=%0d ecc_bist3", c), 8'(b3), 8'd0);
    end

    // Fifteen-iteration build with every iteration failing: count saturates at F.
    s15_start = 1'b1; tick(); s15_start = 1'b0;
    done_cyc = -1; done_num = 0;
    for (int c = 0; c < 96; c++) begin
      chk($sformatf("rep15 c=%0d err_cnt", c), 8'(s15_err),
          8'(sat15((c >= 5) ? ((c - 5) / 6 + 1 > 15 ? 15 : (c - 5) / 6 + 1) : 0)));
      if (s15_done) begin
        done_num++;
        done_cyc = c;
      end
      tick();
    end
    chk("rep15 done cycle", 8'(done_cyc), 8'd90);
    chk("rep15 done count", 8'(done_num), 8'd1);
    chk("rep15 err_cnt", 8'(s15_err), 8'hF);
    chk("rep15 status", 8'(s15_status), 8'd3);
    chk("rep15 pass", 8'(s15_pass), 8'd0);
    chk("rep15 idle", 8'(s15_busy | s15_b3), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ecc_bist_seq.md
ECC_BIST_SEQ -- requirements
Module: ecc_bist_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter SETTLE_CYC, default 4: cycles ecc_bist3 is held high before each result sample (legal 1..15).
REQ-003 Parameter REPEAT_NUM, default 8: number of test iterations per run (legal 1..15).
REQ-004 Port clk  in  1  system clock; all flops on rising edge.
REQ-005 Port rst_n  in  1  asynchronous active-low reset.
REQ-006 Port bist_start  in  1  single-cycle request to start a run.
REQ-007 Port bist_abort  in  1  level; terminates a run in progress.
REQ-008 Port ecc_enable  in  1  ECC path enabled; a run SHALL be permitted only when high.
REQ-009 Port if_data_in  in  38  test-module result word: 38'd0 = iteration pass, 38'h0F = iteration fail.
REQ-010 Port ecc_bist3  out  1  registered; forces the ECC test-module into self-test.
REQ-011 Port bist_busy  out  1  high while a run is in progress.
REQ-012 Port bist_done  out  1  one-cycle pulse at end of a completed run.
REQ-013 Port bist_pass  out  1  sticky result of the last completed run.
REQ-014 Port bist_err_cnt  out  4  failing iterations in the current or last run, saturating.
REQ-015 Port bist_status  out  2  00 idle/never run, 01 running, 10 passed, 11 failed.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, SAMPLE, GAP and DONE, one-hot or binary at implementer's choice.
REQ-017 IDLE: bist_start=1 with ecc_enable=1 -> SETUP; clear bist_err_cnt, bist_pass and iteration counter; bist_status=01.
REQ-018 IDLE: bist_start=1 with ecc_enable=0 -> DONE directly; bist_err_cnt=4'hF, bist_status=11, bist_pass=0, ecc_bist3 never asserted.
REQ-019 SETUP: ecc_bist3=1; settle counter counts SETTLE_CYC cycles, then -> SAMPLE.
REQ-020 SAMPLE (one cycle, ecc_bist3 still 1): if_data_in==38'd0 counts as pass; any other value counts as fail and increments bist_err_cnt.
REQ-021 bist_err_cnt SHALL saturate at 4'hF and never wrap.
REQ-022 GAP (one cycle): ecc_bist3=0; iteration counter increments; if it equals REPEAT_NUM -> DONE, else -> SETUP.
REQ-023 Each iteration SHALL take exactly SETTLE_CYC+2 cycles; defaults: 6 cycles/iteration, 48 cycles SETUP-to-DONE.
REQ-024 DONE (one cycle): bist_done=1; bist_pass=1 and bist_status=10 iff bist_err_cnt==0, else bist_pass=0 and bist_status=11; -> IDLE.
REQ-025 bist_busy SHALL be 1 in SETUP, SAMPLE, GAP and DONE, 0 in IDLE.
REQ-026 bist_start while not IDLE SHALL be ignored, with no restart or counter change.
REQ-027 bist_abort=1 in any non-IDLE state SHALL force IDLE on the next edge: ecc_bist3=0, bist_pass=0, bist_status=00, no bist_done pulse; bist_err_cnt holds.
REQ-028 bist_abort and bist_start in the same IDLE cycle: abort wins and the run does not start.
REQ-029 ecc_enable falling during a run SHALL be treated as abort per REQ-027.
REQ-030 if_data_in SHALL be sampled only in SAMPLE; values in other states are ignored.
REQ-031 All outputs SHALL be driven from flops; no combinational input-to-output path.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, ecc_bist3=0, bist_busy=0, bist_done=0, bist_pass=0, bist_err_cnt=0, bist_status=00, and all counters to 0.
REQ-033 Reset asserted mid-run SHALL behave exactly as REQ-032; deassertion SHALL NOT start a run without a new bist_start.

Verification
REQ-034 Defaults, ecc_enable=1, if_data_in=0, start pulse -> ecc_bist3 high 5 cycles and low 1 cycle, eight times; bist_done once at cycle 48; bist_pass=1, status=10, err_cnt=0.
REQ-035 Defaults, if_data_in=38'h0F during iterations 3 and 7 only -> err_cnt=2, bist_pass=0, status=11, done pulsed once.
REQ-036 REPEAT_NUM=15 test build, if_data_in held 38'h0F -> err_cnt 4'hF, no wrap, status=11.
REQ-037 bist_abort asserted in the 3rd iteration's SETUP -> next cycle ecc_bist3=0, busy=0, status=00, no done; a second start runs a full 48 cycles.
REQ-038 bist_start with ecc_enable=0 -> done one cycle later, err_cnt=F, status=11, ecc_bist3 never high; start repeated while busy is ignored.
REQ-039 rst_n pulsed low at cycle 20 of a run -> all outputs at reset values immediately; no activity until the next bist_start.
